// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: holds the EX request, produces
// {remainder, quotient} after WIDTH steps and handshakes with start_i/ready_o.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   operand_1_i,
  input  logic [WIDTH-1:0]   operand_2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_step_d;
  logic [WIDTH-1:0]   quo_step_d;
  logic [WIDTH-1:0]   quo_fin_s;
  logic [WIDTH-1:0]   rem_fin_s;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? twos_neg(x) : x;
  endfunction

  // Trial subtract of the divisor from the next partial remainder (one extra bit for the borrow).
  assign trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  // One restoring step: keep the difference when it did not borrow.
  always_comb begin
    rem_step_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_step_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_s[WIDTH]) begin
      rem_step_d = trial_s[WIDTH-1:0];
      quo_step_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_step_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Signed results: quotient negative on sign mismatch, remainder follows the dividend.
  assign quo_fin_s = cond_neg(quo_q, neg_quo_q);
  assign rem_fin_s = cond_neg(rem_q, neg_rem_q);

  // Sequencing FSM with registered result and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q  <= 1'b0;
          result_q <= {(2*WIDTH){1'b0}};
          if (start_i && !annul_i) begin
            neg_quo_q <= signed_div_i & (operand_1_i[WIDTH-1] ^ operand_2_i[WIDTH-1]);
            neg_rem_q <= signed_div_i & operand_1_i[WIDTH-1];
            quo_q     <= cond_neg(operand_1_i, signed_div_i & operand_1_i[WIDTH-1]);
            dvs_q     <= cond_neg(operand_2_i, signed_div_i & operand_2_i[WIDTH-1]);
            rem_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            if (operand_2_i == {WIDTH{1'b0}}) begin
              state_q <= S_BY_ZERO;
            end else begin
              state_q <= S_ON;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BY_ZERO: begin
          ready_q  <= 1'b0;
          result_q <= {(2*WIDTH){1'b0}};
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            state_q  <= S_END;
            ready_q  <= 1'b1;
            result_q <= {rem_fin_s, quo_fin_s};
          end else begin
            rem_q <= rem_step_d;
            quo_q <= quo_step_d;
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_END: begin
          // The zero-divisor path arrives here with ready low and raises it now.
          if (annul_i || !start_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
          end else begin
            state_q <= S_END;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ready_q  <= 1'b0;
          result_q <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results and ready
// edges, a negedge monitor pops and compares on every ready_o rise.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic ready_prev = 1'b0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .operand_1_i  (op1),
    .operand_2_i  (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rising ready_o must match the oldest expected entry.
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got result %h with nothing outstanding", result_o);
      end else begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if (result_o !== mon_e.res) begin
          n_err++;
          $display("FAIL result: got %h expected %h", result_o, mon_e.res);
        end
        n_vec++;
        if (cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL latency: ready at edge %0d expected edge %0d", cyc, mon_e.cyc);
        end
      end
    end
    ready_prev = ready_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one division, scramble the inputs after capture, then release or reset in END.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input bit rst_in_end);
    bit got;
    exp_t e;
    @(negedge clk);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    e.res = exp;
    e.cyc = cyc + 1 + lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    op1 = ~a;
    op2 = b ^ 32'h5A5A_5A5A;
    signed_div = ~sgn;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: ready_o low after 60 cycles, expected high", name);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    if (rst_in_end) begin
      #2 rst = 1'b0;
      #1;
      check({name, "_async_rst_result"}, result_o, 64'd0);
      check({name, "_async_rst_ready"}, {63'd0, ready_o}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      @(negedge clk);
      check({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({name, "_hold_result"}, result_o, exp);
      start = 1'b0;
      @(negedge clk);
      check({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
      check({name, "_drop_result"}, result_o, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u_100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 1'b0);
    run_div("s_m7_2",      1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_div("s_7_m2",      1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    run_div("u_5_0",       1'b0, 32'd5,         32'd0,         64'd0,                  2, 1'b0);
    run_div("s_5_0",       1'b1, 32'd5,         32'd0,         64'd0,                  2, 1'b0);
    run_div("s_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33, 1'b0);
    run_div("u_ovf",       1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 33, 1'b0);
    run_div("u_0_5",       1'b0, 32'd0,         32'd5,         64'd0,                 33, 1'b0);

    // start and annul together in IDLE must not launch anything.
    @(negedge clk);
    op1 = 32'd50;
    op2 = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_annul_ready", {63'd0, ready_o}, 64'd0);

    // Annul at iteration 10, then an immediate new division.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    run_div("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

    // Asynchronous reset at iteration 20.
    @(negedge clk);
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("u_10_4", 1'b0, 32'd10, 32'd4, 64'h00000002_00000002, 33, 1'b0);
    run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
